tdm_demux8: RTL and testbench

Receive end of the 8-channel time-division link built from the team's 8:1 mux trees. Takes the serialized bit stream, one bit per strobe with a frame sync marking slot 0, and tracks the slot index with a 3-bit counter. Distributes each bit into its channel's shadow register and presents all eight channels as a parallel word once per frame. Includes sync hunting, flywheel tolerance of missed syncs, and misalignment reporting.

---
 rtl/tdm_demux8.sv | 123 ++++++++++++
 tb/tb_tdm_demux8.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of an 8-channel TDM link.
// Hunts for the frame sync, tracks the slot index, collects slots 0..6 in a
// shadow register and publishes the full 8-bit frame when slot 7 arrives.
// Missed syncs are tolerated up to LOSS_LIMIT-1 consecutive frames.
module tdm_demux8 #(
    parameter int LOSS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       sync,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic [2:0] sel,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Widened so miss+1 never wraps when compared with the limit.
    localparam logic [4:0] LOSS_LIM = 5'(LOSS_LIMIT);

    state_t     state_q, state_d;
    logic [6:0] shadow_q, shadow_d;
    logic [2:0] slot_q, slot_d;
    logic [3:0] miss_q, miss_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       sync_err_q, sync_err_d;
    logic [4:0] miss_inc;

    assign miss_inc = {1'b0, miss_q} + 5'd1;

    // State and datapath registers; reset returns everything to HUNT/zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            shadow_q     <= '0;
            slot_q       <= '0;
            miss_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            slot_q       <= slot_d;
            miss_q       <= miss_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    // Next-state and slot bookkeeping; nothing moves unless a strobe arrives.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        slot_d       = slot_q;
        miss_d       = miss_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    slot_d = 3'd0;
                    if (sync) begin
                        shadow_d[0] = din;
                        slot_d      = 3'd1;
                        miss_d      = 4'd0;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A sync anywhere restarts the frame; off slot 0 the
                        // partial frame is dropped and flagged.
                        sync_err_d  = (slot_q != 3'd0);
                        shadow_d[0] = din;
                        slot_d      = 3'd1;
                        miss_d      = 4'd0;
                    end else if (slot_q == 3'd0) begin
                        if (miss_inc < LOSS_LIM) begin
                            miss_d      = miss_inc[3:0];
                            shadow_d[0] = din;
                            slot_d      = 3'd1;
                        end else begin
                            state_d = HUNT;
                            slot_d  = 3'd0;
                            miss_d  = 4'd0;
                        end
                    end else if (slot_q == 3'd7) begin
                        dout_d       = {din, shadow_q};
                        dout_valid_d = 1'b1;
                        slot_d       = 3'd0;
                    end else begin
                        for (int k = 1; k < 7; k++) begin
                            if (slot_q == 3'(k)) shadow_d[k] = din;
                        end
                        slot_d = slot_q + 3'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        dout       = dout_q;
        dout_valid = dout_valid_q;
        sel        = slot_q;
        locked     = (state_q == LOCKED);
        sync_err   = sync_err_q;
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed and randomized checks of tdm_demux8 against a
// frame-level reference model.
module tb_tdm_demux8;

    localparam int LIM = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [2:0] sel;
    logic       locked;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers and an array of slot bits).
    int         m_locked, m_slot, m_miss;
    bit         m_buf[8];
    logic [7:0] m_dout;
    bit         m_dv, m_se;

    tdm_demux8 #(.LOSS_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .dout(dout), .dout_valid(dout_valid), .sel(sel),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_slot = 0; m_miss = 0;
        for (int k = 0; k < 8; k++) m_buf[k] = 1'b0;
        m_dout = 8'h00; m_dv = 1'b0; m_se = 1'b0;
    endtask

    // One strobe as seen by a receiver: find frame starts, collect bits,
    // publish a word when the eighth bit of an aligned frame arrives.
    task automatic model_strobe(input bit s, input bit d);
        m_dv = 1'b0;
        m_se = 1'b0;
        if (m_locked == 0) begin
            if (s) begin
                m_buf[0] = d; m_slot = 1; m_miss = 0; m_locked = 1;
            end
        end else if (s) begin
            m_se = (m_slot != 0);
            m_buf[0] = d; m_slot = 1; m_miss = 0;
        end else if (m_slot == 0) begin
            if (m_miss + 1 < LIM) begin
                m_miss++; m_buf[0] = d; m_slot = 1;
            end else begin
                m_locked = 0; m_slot = 0; m_miss = 0;
            end
        end else begin
            m_buf[m_slot] = d;
            if (m_slot == 7) begin
                m_dout = 8'h00;
                for (int k = 0; k < 8; k++) if (m_buf[k]) m_dout += 8'(1 << k);
                m_dv = 1'b1;
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
    endtask

    // Drive one cycle, update the model, compare every output after the edge.
    task automatic step(input bit r, input bit e, input bit s, input bit d);
        rst = r; en = e; sync = s; din = d;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else if (e) model_strobe(s, d);
        else begin m_dv = 1'b0; m_se = 1'b0; end
        chk("dout", dout, m_dout);
        chk("dout_valid", {7'd0, dout_valid}, {7'd0, m_dv});
        chk("sel", {5'd0, sel}, 8'(m_slot));
        chk("locked", {7'd0, locked}, 8'(m_locked));
        chk("sync_err", {7'd0, sync_err}, {7'd0, m_se});
    endtask

    task automatic send_frame(input logic [7:0] w, input bit with_sync);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, (k == 0) && with_sync, w[k]);
    endtask

    logic [7:0] pat;

    initial begin
        pat = 8'h4D;
        model_reset();

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_dout", dout, 8'h00);
        chk("reset_locked", {7'd0, locked}, 8'h00);

        // Hunt ignores data without sync
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("hunt_locked", {7'd0, locked}, 8'h00);
        chk("hunt_sel", {5'd0, sel}, 8'h00);
        chk("hunt_dout", dout, 8'h00);

        // Lock and decode 1,0,1,1,0,0,1,0 -> 8'h4D
        step(1'b0, 1'b1, 1'b1, pat[0]);
        chk("lock_first_edge", {7'd0, locked}, 8'h01);
        for (int k = 1; k < 8; k++) step(1'b0, 1'b1, 1'b0, pat[k]);
        chk("decode_word", dout, 8'h4D);
        chk("decode_valid", {7'd0, dout_valid}, 8'h01);
        chk("decode_sel", {5'd0, sel}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("valid_one_cycle", {7'd0, dout_valid}, 8'h00);

        // Flywheel: frame 2 without sync still decodes, frame 3 start loses lock
        send_frame(8'hA6, 1'b0);
        chk("flywheel_word", dout, 8'hA6);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("loss_locked", {7'd0, locked}, 8'h00);
        chk("loss_sel", {5'd0, sel}, 8'h00);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("loss_dout_held", dout, 8'hA6);

        // Misalignment at slot 5, then at slot 7
        send_frame(8'h3C, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, k == 0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("misalign_err", {7'd0, sync_err}, 8'h01);
        chk("misalign_sel", {5'd0, sel}, 8'h01);
        for (int k = 1; k < 8; k++) step(1'b0, 1'b1, 1'b0, k[0]);
        chk("misalign_word", dout, 8'hAA);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, k == 0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("misalign7_err", {7'd0, sync_err}, 8'h01);
        chk("misalign7_noupd", {7'd0, dout_valid}, 8'h00);
        chk("misalign7_dout", dout, 8'hAA);

        // Sparse strobes with sync/din toggling between strobes
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, ~pat[k]);
            step(1'b0, 1'b0, 1'b0, pat[k]);
            step(1'b0, 1'b1, k == 0, pat[k]);
        end
        chk("sparse_word", dout, 8'h4D);
        chk("sparse_valid", {7'd0, dout_valid}, 8'h01);

        // Reset mid-frame, then clean restart
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, k == 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_sel", {5'd0, sel}, 8'h00);
        chk("midrst_valid", {7'd0, dout_valid}, 8'h00);
        send_frame(8'h96, 1'b1);
        chk("restart_word", dout, 8'h96);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
